// File: rtl/msp_trace_ctrl.sv
// msp_trace_ctrl: instruction-trace capture controller for the openMSP430 debug
// environment. It captures decoded PCs into a circular buffer using an
// arm -> trigger -> post-trigger -> done sequence. Captured entries are read
// back by index, where index 0 is the oldest valid entry.
//
// Optional feature macro: TRACE_IRQ_FILTER_EN
//   When defined, interrupt-entry decodes are not captured, cannot trigger,
//   and do not consume post-trigger count. rd_data[16] always reads 0.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | out of reset, nothing captured, waiting for arm
// ARMED  | capturing every decode, watching for a trigger PC match
// POST   | trigger seen, capturing until remaining reaches zero
// DONE   | capture frozen, buffer readable, arm restarts a capture
module msp_trace_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int PW    = 8
) (
   input  logic          mclk,
   input  logic          reset_n,
   input  logic          decode,
   input  logic [15:0]   inst_pc_in,
   input  logic          irq_detect,
   input  logic          arm,
   input  logic          stop,
   input  logic          trig_en,
   input  logic [15:0]   trig_pc,
   input  logic [PW-1:0] post_cnt,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_idx,
   output logic          rd_ack,
   output logic [16:0]   rd_data,
   output logic [1:0]    state,
   output logic [AW:0]   count,
   output logic          wrapped,
   output logic          trig_hit
);

`ifdef TRACE_IRQ_FILTER_EN
   localparam logic FILTER = 1'b1;
`else
   localparam logic FILTER = 1'b0;
`endif

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr;
   logic [PW-1:0] remaining, remaining_d;
   logic          trig_hit_d;
   logic          clr;
   logic          cap;
   logic          trig;
   logic [16:0]   mem [DEPTH];

   logic [AW-1:0] oldest;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic [16:0]   rd_word;

   assign cap  = decode && (state_q == S_ARMED || state_q == S_POST) &&
                 !(FILTER && irq_detect);
   assign trig = cap && (state_q == S_ARMED) && trig_en && (inst_pc_in == trig_pc);

   // Next-state and control decode; stop is applied last so it overrides the trigger
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining;
      trig_hit_d  = trig_hit;
      clr         = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm) begin
               state_d     = S_ARMED;
               clr         = 1'b1;
               trig_hit_d  = 1'b0;
               remaining_d = '0;
            end
         end
         S_ARMED: begin
            if (trig) begin
               trig_hit_d  = 1'b1;
               remaining_d = post_cnt;
               state_d     = (post_cnt == '0) ? S_DONE : S_POST;
            end
            if (stop) state_d = S_DONE;
         end
         S_POST: begin
            if (cap) begin
               remaining_d = remaining - PW'(1);
               if (remaining <= PW'(1)) state_d = S_DONE;
            end
            if (stop) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state registers
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         remaining <= '0;
         trig_hit  <= 1'b0;
      end else begin
         state_q   <= state_d;
         remaining <= remaining_d;
         trig_hit  <= trig_hit_d;
      end
   end

   // Write pointer, saturating fill count and wrap flag
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         count   <= '0;
         wrapped <= 1'b0;
      end else if (clr) begin
         wr_ptr  <= '0;
         count   <= '0;
         wrapped <= 1'b0;
      end else if (cap) begin
         wr_ptr <= wr_ptr + AW'(1);
         if (count != DEPTH_C) count <= count + (AW+1)'(1);
         if (wr_ptr == LAST_C) wrapped <= 1'b1;
      end
   end

   // Trace RAM, deliberately left unreset; count gates what is ever returned
   always_ff @(posedge mclk) begin
      if (cap) mem[wr_ptr] <= {irq_detect & ~FILTER, inst_pc_in};
   end

   assign oldest   = wrapped ? wr_ptr : '0;
   assign rd_addr  = oldest + rd_idx;
   assign rd_valid = ({1'b0, rd_idx} < count);
   assign rd_word  = mem[rd_addr];

   // Registered read port; uses pre-write pointer, count and contents
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ack  <= 1'b0;
         rd_data <= '0;
      end else begin
         rd_ack <= rd_req;
         if (rd_req) rd_data <= rd_valid ? {rd_word[16] & ~FILTER, rd_word[15:0]} : 17'd0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_msp_trace_ctrl.sv
// Directed bench for msp_trace_ctrl. Read requests push their expected word,
// taken from a list of captured entries, into a queue. Each acknowledged read
// pops that queue and compares.
module tb_msp_trace_ctrl;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int PW    = 8;

`ifdef TRACE_IRQ_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic          mclk = 1'b0;
   logic          reset_n;
   logic          decode, irq_detect, arm, stop, trig_en, rd_req;
   logic [15:0]   inst_pc_in, trig_pc;
   logic [PW-1:0] post_cnt;
   logic [AW-1:0] rd_idx;
   logic          rd_ack, wrapped, trig_hit;
   logic [16:0]   rd_data;
   logic [1:0]    state;
   logic [AW:0]   count;

   int vectors = 0;
   int errors  = 0;
   logic [16:0] model[$];
   logic [16:0] exp_q[$];
   logic [16:0] last_exp;

   msp_trace_ctrl #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) dut (
      .mclk(mclk), .reset_n(reset_n), .decode(decode), .inst_pc_in(inst_pc_in),
      .irq_detect(irq_detect), .arm(arm), .stop(stop), .trig_en(trig_en),
      .trig_pc(trig_pc), .post_cnt(post_cnt), .rd_req(rd_req), .rd_idx(rd_idx),
      .rd_ack(rd_ack), .rd_data(rd_data), .state(state), .count(count),
      .wrapped(wrapped), .trig_hit(trig_hit)
   );

   always #5 mclk = ~mclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] exp_read(input int idx);
      int n, valid;
      n     = model.size();
      valid = (n > DEPTH) ? DEPTH : n;
      if (idx >= valid) return 17'd0;
      return model[n - valid + idx];
   endfunction

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
      model.delete();
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic dec(input logic [15:0] pc, input logic irq, input bit capt, input logic stp);
      decode     = 1'b1;
      inst_pc_in = pc;
      irq_detect = irq;
      stop       = stp;
      step();
      decode     = 1'b0;
      irq_detect = 1'b0;
      stop       = 1'b0;
      if (capt) model.push_back({irq, pc});
   endtask

   // Back-to-back reads of n consecutive indices, then one idle cycle
   task automatic rd_burst(input string tag, input int first, input int n);
      logic [16:0] e;
      for (int k = 0; k < n; k++) begin
         rd_req = 1'b1;
         rd_idx = AW'(first + k);
         exp_q.push_back(exp_read(first + k));
         step();
         check({tag, "_ack"}, {31'd0, rd_ack}, 32'd1);
         if (exp_q.size() != 0) begin
            e        = exp_q.pop_front();
            last_exp = e;
            check($sformatf("%s_data%0d", tag, first + k), {15'd0, rd_data}, {15'd0, e});
         end
      end
      rd_req = 1'b0;
      step();
      check({tag, "_ack_low"}, {31'd0, rd_ack}, 32'd0);
      check({tag, "_hold"}, {15'd0, rd_data}, {15'd0, last_exp});
   endtask

   initial begin
      reset_n = 1'b0; decode = 1'b0; irq_detect = 1'b0; arm = 1'b0; stop = 1'b0;
      trig_en = 1'b0; rd_req = 1'b0; inst_pc_in = '0; trig_pc = '0; post_cnt = '0;
      rd_idx = '0; last_exp = '0;
      repeat (3) @(posedge mclk);
      #1 reset_n = 1'b1;

      // Reset values
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_count", {27'd0, count}, 32'd0);
      check("rst_wrapped", {31'd0, wrapped}, 32'd0);
      check("rst_trig_hit", {31'd0, trig_hit}, 32'd0);
      check("rst_rd_ack", {31'd0, rd_ack}, 32'd0);
      rd_burst("rst_rd", 0, 1);

      // stop ignored in IDLE
      pulse_stop();
      check("idle_stop", {30'd0, state}, 32'd0);

      // Wrap with stop
      pulse_arm();
      check("wrap_armed", {30'd0, state}, 32'd1);
      for (int i = 0; i < 20; i++) dec(16'hC000 + 16'(2 * i), 1'b0, 1'b1, 1'b0);
      arm = 1'b1; step(); arm = 1'b0;
      check("armed_arm_ignored", {30'd0, state}, 32'd1);
      pulse_stop();
      check("wrap_state", {30'd0, state}, 32'd3);
      check("wrap_count", {27'd0, count}, 32'd16);
      check("wrap_wrapped", {31'd0, wrapped}, 32'd1);
      rd_burst("wrap_rd", 0, 1);
      rd_burst("wrap_rd", 15, 1);
      rd_burst("wrap_all", 0, 16);

      // Trigger with post count
      trig_en = 1'b1; trig_pc = 16'hC010; post_cnt = 8'd3;
      pulse_arm();
      check("trg_clr_count", {27'd0, count}, 32'd0);
      check("trg_clr_wrapped", {31'd0, wrapped}, 32'd0);
      check("trg_clr_hit", {31'd0, trig_hit}, 32'd0);
      for (int i = 0; i < 9; i++) dec(16'hC000 + 16'(2 * i), 1'b0, 1'b1, 1'b0);
      check("trg_hit", {31'd0, trig_hit}, 32'd1);
      check("trg_post", {30'd0, state}, 32'd2);
      dec(16'hC012, 1'b0, 1'b1, 1'b0);
      dec(16'hC014, 1'b0, 1'b1, 1'b0);
      check("trg_still_post", {30'd0, state}, 32'd2);
      dec(16'hC016, 1'b0, 1'b1, 1'b0);
      check("trg_done", {30'd0, state}, 32'd3);
      dec(16'hC018, 1'b0, 1'b0, 1'b0);
      check("trg_count", {27'd0, count}, 32'd12);
      rd_burst("trg_rd", 10, 4);

      // Trigger with post_cnt=0 and simultaneous stop
      trig_pc = 16'hC004; post_cnt = 8'd0;
      pulse_arm();
      dec(16'hC000, 1'b0, 1'b1, 1'b0);
      dec(16'hC002, 1'b0, 1'b1, 1'b0);
      check("p0_not_hit", {31'd0, trig_hit}, 32'd0);
      dec(16'hC004, 1'b0, 1'b1, 1'b1);
      check("p0_hit", {31'd0, trig_hit}, 32'd1);
      check("p0_state", {30'd0, state}, 32'd3);
      check("p0_count", {27'd0, count}, 32'd3);
      rd_burst("p0_rd", 2, 1);

      // Interrupt decode while ARMED
      trig_en = 1'b0;
      pulse_arm();
      dec(16'hFFFE, 1'b1, !FILT, 1'b0);
      check("irq_count", {27'd0, count}, FILT ? 32'd0 : 32'd1);
      rd_burst("irq_rd", 0, 1);

      // Reset in the middle of POST
      pulse_stop();
      trig_en = 1'b1; trig_pc = 16'hD000; post_cnt = 8'd5;
      pulse_arm();
      dec(16'hD000, 1'b0, 1'b1, 1'b0);
      dec(16'hD002, 1'b0, 1'b1, 1'b0);
      check("mid_post", {30'd0, state}, 32'd2);
      #3 reset_n = 1'b0;
      #1;
      check("mid_rst_state", {30'd0, state}, 32'd0);
      check("mid_rst_count", {27'd0, count}, 32'd0);
      check("mid_rst_hit", {31'd0, trig_hit}, 32'd0);
      model.delete();
      step();
      reset_n = 1'b1;
      trig_en = 1'b0;
      pulse_arm();
      dec(16'hE000, 1'b0, 1'b1, 1'b0);
      dec(16'hE002, 1'b0, 1'b1, 1'b0);
      check("mid_count", {27'd0, count}, 32'd2);
      check("mid_hit", {31'd0, trig_hit}, 32'd0);
      rd_burst("mid_rd", 1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/msp_trace_ctrl.md
# msp_trace_ctrl

Instruction-trace capture controller for the openMSP430 simulation and debug environment. It sequences an arm, trigger, post-trigger, done capture of decoded instruction PCs into a circular trace buffer and serves indexed read-back. It sits beside the core's decode logic, driven by the core's decode strobe and instruction PC. Read-back goes to a bench monitor or a debug-interface register window.

## Interface
Parameters:
- DEPTH, 16, number of trace entries; must be a power of two, minimum 4.
- AW, 4, log2(DEPTH).
- PW, 8, width of the post-trigger count.

Ports:
- mclk  in  1  main system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- decode  in  1  one-cycle strobe per decoded instruction.
- inst_pc_in  in  16  PC of the instruction being decoded; valid when decode=1.
- irq_detect  in  1  current decode is an interrupt entry; valid when decode=1.
- arm  in  1  pulse: start a capture.
- stop  in  1  pulse: end a capture.
- trig_en  in  1  enables PC-match trigger.
- trig_pc  in  16  trigger address.
- post_cnt  in  PW  entries captured after the trigger entry.
- rd_req  in  1  read request.
- rd_idx  in  AW  read index, where 0 is the oldest valid entry.
- rd_ack  out  1  read data valid.
- rd_data  out  17  {irq flag, pc}.
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- count  out  AW+1  number of valid entries, saturating at DEPTH.
- wrapped  out  1  write pointer has wrapped since the last arm.
- trig_hit  out  1  trigger occurred in the current or last capture.

## Operation
- **Capture condition:** a decode cycle in ARMED or POST writes {irq_detect, inst_pc_in} at wr_ptr. wr_ptr then advances modulo DEPTH. count increments and saturates at DEPTH. wrapped is set when wr_ptr goes from DEPTH-1 to 0.
- **IDLE:**
  - arm=1 goes to ARMED.
  - stop is ignored.
- **ARMED:**
  - A captured decode with trig_en=1 and inst_pc_in==trig_pc sets trig_hit and loads remaining=post_cnt.
  - If post_cnt=0, go to DONE. Otherwise go to POST.
  - The trigger entry itself is captured.
- **POST:** each captured decode decrements remaining. The decode that brings remaining to 0 is captured and moves the state to DONE in the same edge.
- **stop in ARMED or POST:** goes to DONE. A decode in the same cycle is still captured.
- **stop vs. trigger:** stop has priority over the trigger in the same cycle. The entry is still captured, trig_hit is set, and the state goes to DONE.
- **arm in ARMED or POST:** ignored.
- **arm in DONE:** clears wr_ptr, count, wrapped and trig_hit, then enters ARMED.
- **arm and stop together in IDLE or DONE:** arm wins.
- **Buffer RAM:** not reset. Entries at or beyond count are never returned.
- **Read-back:**
  - rd_req is accepted in any state.
  - The physical address is (oldest + rd_idx) mod DEPTH, where oldest = wrapped ? wr_ptr : 0.
  - If rd_idx >= count, rd_data=0.
  - A read in the same cycle as a write returns the pre-write buffer contents and uses the pre-write wr_ptr and count.

## Timing
- **Reset values:** state=0, count=0, wrapped=0, trig_hit=0, rd_ack=0, rd_data=0, wr_ptr=0, remaining=0.
- **Capture latency:** the entry is written on the rising edge where decode=1. count and wr_ptr update on that same edge.
- **State transitions:** registered. The new state is visible one cycle after the causing input.
- **Read latency:**
  - rd_ack=1 and rd_data are valid in the cycle after rd_req=1.
  - rd_ack is a one-cycle pulse per request.
  - Back-to-back requests every cycle are supported.
  - rd_data holds its value when rd_ack=0.
- **Reset mid-capture:** an asynchronous reset_n assertion returns all registers to their reset values immediately, regardless of state.

## Configuration
- **TRACE_IRQ_FILTER_EN defined:**
  - Decodes with irq_detect=1 are neither captured nor trigger candidates.
  - They do not decrement remaining.
  - rd_data[16] is always 0.
- **TRACE_IRQ_FILTER_EN undefined:** interrupt decodes are captured with rd_data[16]=1 and may trigger on PC match.

## Test plan
- **Reset:** reset_n low for 3 cycles, release. Required: state=0, count=0, wrapped=0, trig_hit=0, rd_ack=0. A read with rd_idx=0 returns rd_data=0 with rd_ack=1 one cycle later.
- **Wrap with stop:**
  - Stimulus: arm, then 20 decodes with PCs 0xC000+2i (i=0..19), trig_en=0, then stop.
  - Required: state=3, count=16, wrapped=1.
  - rd_idx=0 returns 0x0C008 and rd_idx=15 returns 0x0C026.
- **Trigger with post count:**
  - Stimulus: arm, trig_pc=0xC010, post_cnt=3, PCs 0xC000 upward in steps of 2.
  - Required: trig_hit=1, DONE after the 0xC016 decode, count=12, and a decode of 0xC018 is not captured.
- **post_cnt=0 with simultaneous stop:**
  - Stimulus: trigger decode at 0xC004 with stop=1 in the same cycle.
  - Required: entry captured, trig_hit=1, state=3 next cycle, count=3.
- **Interrupt decode:** a decode with irq_detect=1 and PC 0xFFFE while ARMED.
  - With TRACE_IRQ_FILTER_EN: count unchanged.
  - Without: the entry reads 0x1FFFE.
- **Reset mid-POST:** reset_n asserted mid-POST, then arm and 2 decodes. Required: count=2, trig_hit=0, rd_idx=1 returns the second PC.
